// File: rtl/lut_rb_pkg.sv
// Shared state encoding and sizing helper for the LUT readback serializer.
package lut_rb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ADDR  = 2'd1;
    localparam state_t SHIFT = 2'd2;
    localparam state_t DONE  = 2'd3;

    // Beat-counter width; never narrower than one bit.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lut_rb_piso.sv
// Parallel-load shift register with beat counter, LSB first.
module lut_rb_piso
    import lut_rb_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             bit0,
    output logic             last_beat
);

    localparam int CW = cnt_bits(WIDTH);

    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;

    assign bit0      = sr[0];
    assign last_beat = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= din;
            cnt <= '0;
        end else if (shift) begin
            sr  <= sr >> 1;
            cnt <= last_beat ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/lut_readback_serializer.sv
// Sweeps the shared LUT read address and streams every LUT bit,
// address-major, over a valid/ready serial port.
module lut_readback_serializer
    import lut_rb_pkg::*;
#(
    parameter int ADDR_BITS = 4,
    parameter int NUM_LUTS  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [ADDR_BITS-1:0] rb_addr,
    input  logic [NUM_LUTS-1:0]  rb_data,
    output logic                 write_hold,
    output logic                 busy,
    output logic                 dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 dout_last,
    output logic                 done
);

    localparam int MEM_SIZE = 2 ** ADDR_BITS;

    state_t state;
    logic   xfer;
    logic   at_end;
    logic   bit0;
    logic   last_beat;

    assign xfer   = (state == SHIFT) && dout_ready;
    assign at_end = (rb_addr == ADDR_BITS'(MEM_SIZE - 1));

    lut_rb_piso #(
        .WIDTH(NUM_LUTS)
    ) u_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ADDR),
        .shift    (xfer),
        .din      (rb_data),
        .bit0     (bit0),
        .last_beat(last_beat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rb_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rb_addr <= '0;
                    if (start) state <= ADDR;
                end
                ADDR: state <= SHIFT;
                SHIFT: begin
                    if (xfer && last_beat) begin
                        if (at_end) begin
                            state <= DONE;
                        end else begin
                            rb_addr <= rb_addr + ADDR_BITS'(1);
                            state   <= ADDR;
                        end
                    end
                end
                DONE: begin
                    rb_addr <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign write_hold = busy;
    assign dout_valid = (state == SHIFT);
    assign dout       = dout_valid & bit0;
    assign dout_last  = dout_valid & at_end & last_beat;
    assign done       = (state == DONE);

endmodule

// File: doc/lut_readback_serializer.md
Name: lut_readback_serializer

Overview:
- Reads back the contents of NUM_LUTS SLICEM LUT latch blocks by sweeping their shared read address, and serializes the bits onto a valid/ready bit stream.
- Used for configuration verification and debug readback; drives the read-address side of the LUT latch blocks and consumes their read-data outputs.
- While a scan is active, asserts a write-hold so user writes cannot change memory mid-scan.

Parameters:
- ADDR_BITS, 4, LUT address width.
- MEM_SIZE, 2**ADDR_BITS, bits per LUT; derived, not overridden.
- NUM_LUTS, 2, number of LUT blocks scanned in parallel (≥1).

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a scan; sampled only in IDLE.
- rb_addr  out  ADDR_BITS  read address driven to all LUT blocks.
- rb_data  in  NUM_LUTS  combinational read data; bit i comes from LUT i at rb_addr.
- write_hold  out  1  high while a scan is active; gates user write_en at integration.
- busy  out  1  high in every state except IDLE.
- dout  out  1  serial data bit.
- dout_valid  out  1  dout is valid.
- dout_ready  in  1  sink accepts; a beat transfers when dout_valid & dout_ready at a clk edge.
- dout_last  out  1  marks the final beat of the scan.
- done  out  1  one-cycle pulse after the final beat transfers.

Behaviour:
- Reset (rst high at a clk edge) forces:
  - state IDLE;
  - rb_addr = 0, dout = 0;
  - dout_valid, dout_last, done, busy and write_hold = 0;
  - shift register and beat counter = 0.
- Reset wins over every other input in the same cycle, including start.
- Reset mid-scan aborts immediately; there is no partial done and no further beats.
- States: IDLE, ADDR, SHIFT, DONE.
- IDLE:
  - start=1 → ADDR next cycle with rb_addr = 0.
  - start=0 → stay in IDLE.
- ADDR (exactly one cycle):
  - rb_addr is held stable for the whole cycle.
  - At the clk edge, capture rb_data into a NUM_LUTS-bit shift register and go to SHIFT.
- SHIFT:
  - dout_valid = 1; dout = shift register bit 0, so LUT 0 is sent first.
  - On each transfer, shift right by one and increment the beat counter (0..NUM_LUTS-1).
  - dout and dout_last must not change while dout_valid=1 and dout_ready=0.
  - After transfer of beat NUM_LUTS-1:
    - if rb_addr < MEM_SIZE-1: rb_addr += 1, beat counter = 0, go to ADDR;
    - if rb_addr = MEM_SIZE-1: go to DONE.
  - rb_addr never wraps within a scan.
- dout_last = 1 only in SHIFT, when rb_addr = MEM_SIZE-1 and beat counter = NUM_LUTS-1.
- DONE (one cycle): done = 1, busy = 1; next state IDLE, with rb_addr reset to 0.
- busy = write_hold = (state != IDLE).
- start in any state other than IDLE is ignored; it is not queued.
- Stream order is address-major: (a0,L0), (a0,L1), …, (a0,L[N-1]), (a1,L0), …
- Total beats per scan = MEM_SIZE*NUM_LUTS.
- Latency with dout_ready held high:
  - first dout_valid two cycles after the start cycle;
  - full scan occupies MEM_SIZE*(1+NUM_LUTS) cycles of ADDR/SHIFT, plus 1 cycle of DONE.
- Backpressure: any number of dout_ready=0 cycles is tolerated; there is no timeout.
- dout_valid is never deasserted once raised until the beat transfers.

Decomposition:
- Package lut_rb_pkg:
  - state enum: IDLE/ADDR/SHIFT/DONE;
  - localparam beat-counter width $clog2(NUM_LUTS) (min 1).
- Sub-module lut_rb_piso:
  - NUM_LUTS-bit parallel-load shift register with load, shift-enable, bit-0 output and beat counter;
  - asserts last_beat at count NUM_LUTS-1.
- FSM and address counter stay in the top module.

Test Plan:
- Basic scan, defaults, ready always high, LUT0 = 16'hA5C3, LUT1 = 16'h0F0F, pulse start → exactly 32 beats:
  - first six bits 1,1,1,1,0,1;
  - dout_last only on beat 32; done pulses the cycle after;
  - 48 ADDR/SHIFT cycles plus 1 DONE cycle; busy and write_hold high throughout.
- Backpressure: same data, dout_ready toggling 1,0,0,1,… → identical 32-bit sequence; dout and dout_last stable during every stalled cycle.
- Start while busy: pulse start at beat 5 → no restart, still 32 beats, a single done.
- Reset mid-scan: assert rst at beat 10 → next cycle everything is zero; a later start yields a full 32-beat scan from address 0.
- start and rst in the same cycle → remains IDLE, busy=0.
- NUM_LUTS=1, ADDR_BITS=2, LUT = 4'b1001 → beats 1,0,0,1, last on beat 4, 8 ADDR/SHIFT cycles.
